// File: rtl/hamming74_decoder.sv
// hamming74_decoder: streaming Hamming(7,4) single-error-correcting decoder.
// Two registered stages with valid/ready backpressure and saturating stats.
package hamming74_pkg;

  typedef struct packed {
    logic [6:0] code;
    logic [2:0] syn;
  } s1_t;

endpackage

module hamming74_decoder
  import hamming74_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       code_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       data_out,
  output logic [2:0]       syndrome_out,
  output logic             err_corr,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] corr_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic       s1_valid;
  s1_t        s1_q;
  s1_t        s1_d;
  logic       s2_valid;
  logic       s1_en;
  logic       s2_en;
  logic       fire;
  logic [7:0] onehot;
  logic [6:0] fixed;

  assign s2_en     = !s2_valid | out_ready;
  assign s1_en     = !s1_valid | s2_en;
  assign in_ready  = s1_en;
  assign out_valid = s2_valid;
  assign fire      = s2_valid & out_ready;

  // syndrome {s4,s2,s1} of the incoming word
  always_comb begin
    s1_d.code   = code_in;
    s1_d.syn[0] = code_in[0] ^ code_in[2]
                ^ code_in[4] ^ code_in[6];
    s1_d.syn[1] = code_in[1] ^ code_in[2]
                ^ code_in[5] ^ code_in[6];
    s1_d.syn[2] = code_in[3] ^ code_in[4]
                ^ code_in[5] ^ code_in[6];
  end

  // stage 1: capture codeword and syndrome
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_q <= s1_d;
      end
    end
  end

  // invert code[S-1]; S=0 shifts the one-hot out
  always_comb begin
    onehot = 8'd1 << s1_q.syn;
    fixed  = s1_q.code ^ onehot[7:1];
  end

  // stage 2: corrected data and status
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid     <= 1'b0;
      data_out     <= '0;
      syndrome_out <= '0;
      err_corr     <= 1'b0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        data_out     <= {fixed[6], fixed[5],
                         fixed[4], fixed[2]};
        syndrome_out <= s1_q.syn;
        err_corr     <= |s1_q.syn;
      end
    end
  end

  // saturating link statistics, clear wins
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      word_cnt <= '0;
      corr_cnt <= '0;
    end else if (fire) begin
      if (word_cnt != CNT_MAX) begin
        word_cnt <= word_cnt + CNT_ONE;
      end
      if (err_corr && corr_cnt != CNT_MAX) begin
        corr_cnt <= corr_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_hamming74_decoder.sv
// tb_hamming74_decoder: scoreboard bench for the Hamming(7,4) decoder.
// A narrow CNT_W=2 copy shares the stimulus to exercise saturation.
module tb_hamming74_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic       clr_cnt = 1'b0;
  logic [6:0] code_in = '0;

  logic        in_ready, out_valid, err_corr;
  logic [3:0]  data_out;
  logic [2:0]  syndrome_out;
  logic [15:0] word_cnt, corr_cnt;

  logic       n_in_ready, n_out_valid, n_err_corr;
  logic [3:0] n_data_out;
  logic [2:0] n_syndrome_out;
  logic [1:0] n_word_cnt, n_corr_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0] data;
    logic [2:0] syn;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   wc = 0, cc = 0, nwc = 0, ncc = 0;
  bit   armed = 0;

  always #5 clk = ~clk;

  hamming74_decoder #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .code_in(code_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .syndrome_out(syndrome_out),
    .err_corr(err_corr), .clr_cnt(clr_cnt),
    .word_cnt(word_cnt), .corr_cnt(corr_cnt)
  );

  hamming74_decoder #(.CNT_W(2)) ndut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(n_in_ready),
    .code_in(code_in),
    .out_valid(n_out_valid), .out_ready(out_ready),
    .data_out(n_data_out), .syndrome_out(n_syndrome_out),
    .err_corr(n_err_corr), .clr_cnt(clr_cnt),
    .word_cnt(n_word_cnt), .corr_cnt(n_corr_cnt)
  );

  function automatic logic [6:0] enc(input logic [3:0] d);
    enc = {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3],
           d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
  endfunction

  // nearest codeword search: the code is perfect, exactly one hit
  function automatic exp_t model(input logic [6:0] c);
    exp_t r;
    logic [6:0] f;
    r = '0;
    for (int d = 0; d < 16; d++) begin
      for (int e = 0; e < 8; e++) begin
        f = enc(4'(d));
        if (e != 0) f[e-1] = ~f[e-1];
        if (f == c) begin
          r.data = 4'(d);
          r.syn  = 3'(e);
          r.err  = (e != 0);
        end
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: compare head while valid, pop on handshake
  always @(negedge clk) begin
    exp_t h;
    bit   fire;
    if (rst) begin
      q.delete();
      wc = 0; cc = 0; nwc = 0; ncc = 0;
      armed = 1;
    end else if (armed) begin
      chk("word_cnt", word_cnt, wc);
      chk("corr_cnt", corr_cnt, cc);
      chk("n_word_cnt", n_word_cnt, nwc);
      chk("n_corr_cnt", n_corr_cnt, ncc);
      fire = 0;
      h = '0;
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out", out_valid, 0);
        end else begin
          h = q[0];
          chk("data_out", data_out, h.data);
          chk("syndrome_out", syndrome_out, h.syn);
          chk("err_corr", err_corr, h.err);
          chk("n_data_out", n_data_out, h.data);
          chk("n_syndrome", n_syndrome_out, h.syn);
          chk("n_err_corr", n_err_corr, h.err);
          if (out_ready) begin
            fire = 1;
            void'(q.pop_front());
          end
        end
      end
      if (clr_cnt) begin
        wc = 0; cc = 0; nwc = 0; ncc = 0;
      end else if (fire) begin
        if (wc < 65535) wc++;
        if (nwc < 3) nwc++;
        if (h.err && cc < 65535) cc++;
        if (h.err && ncc < 3) ncc++;
      end
      if (in_valid && in_ready) q.push_back(model(code_in));
    end
  end

  // called at posedge+1; returns at posedge+1 after the handshake
  task automatic send(input logic [6:0] c);
    int g;
    g = 0;
    in_valid = 1'b1;
    code_in  = c;
    @(negedge clk);
    while (!in_ready && g < 50) begin
      g++;
      @(negedge clk);
    end
    chk("send_ready", in_ready & n_in_ready, 1);
    @(posedge clk); #1;
  endtask

  // ends on a negedge once the last handshake has committed
  task automatic drain();
    int g;
    g = 0;
    in_valid = 1'b0;
    while (q.size() != 0 && g < 100) begin
      g++;
      @(negedge clk);
    end
    chk("drain_empty", q.size(), 0);
    @(negedge clk);
  endtask

  task automatic to_drive();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [6:0] c;
    logic [6:0] w [5];

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_syndrome", syndrome_out, 0);
    chk("rst_err_corr", err_corr, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_corr_cnt", corr_cnt, 0);
    to_drive();

    // clean word and two-cycle latency
    send(7'h55);
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_cycle1_valid", out_valid, 0);
    @(negedge clk);
    chk("lat_cycle2_valid", out_valid, 1);
    chk("clean_data", data_out, 4'hB);
    chk("clean_syn", syndrome_out, 3'b000);
    chk("clean_err", err_corr, 0);
    @(negedge clk);
    chk("clean_word_cnt", word_cnt, 1);
    chk("clean_idle", out_valid, 0);
    to_drive();

    // data-bit error
    send(7'h45);
    drain();
    chk("dbit_word_cnt", word_cnt, 2);
    chk("dbit_corr_cnt", corr_cnt, 1);
    to_drive();

    // parity-bit error, then all zeros
    send(7'h7E);
    send(7'h00);
    drain();
    chk("pbit_word_cnt", word_cnt, 4);
    chk("pbit_corr_cnt", corr_cnt, 2);
    to_drive();

    // clear, then full-rate exhaustive sweep
    clr_cnt = 1'b1;
    to_drive();
    clr_cnt = 1'b0;
    @(negedge clk);
    chk("clr_word_cnt", word_cnt, 0);
    chk("clr_corr_cnt", corr_cnt, 0);
    to_drive();
    for (int d = 0; d < 16; d++) begin
      for (int e = 0; e < 8; e++) begin
        c = enc(4'(d));
        if (e != 0) c[e-1] = ~c[e-1];
        send(c);
      end
    end
    drain();
    chk("sweep_word_cnt", word_cnt, 128);
    chk("sweep_corr_cnt", corr_cnt, 112);
    chk("sweep_n_word_sat", n_word_cnt, 3);
    chk("sweep_n_corr_sat", n_corr_cnt, 3);
    to_drive();

    // backpressure: 5 words against a 4-cycle stall
    w[0] = 7'h55; w[1] = 7'h45; w[2] = 7'h7E;
    w[3] = enc(4'h6) ^ 7'h40; w[4] = enc(4'h9);
    out_ready = 1'b0;
    send(w[0]);
    send(w[1]);
    in_valid = 1'b1;
    code_in  = w[2];
    @(negedge clk);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    to_drive();
    @(negedge clk);
    chk("bp_in_ready_hold", in_ready, 0);
    to_drive();
    out_ready = 1'b1;
    send(w[2]);
    send(w[3]);
    send(w[4]);
    drain();
    chk("bp_word_cnt", word_cnt, 133);
    to_drive();

    // saturation on the narrow counters
    clr_cnt = 1'b1;
    to_drive();
    clr_cnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(enc(4'(i + 3)) ^ 7'h10);
    end
    drain();
    chk("sat_n_word_cnt", n_word_cnt, 3);
    chk("sat_n_corr_cnt", n_corr_cnt, 3);
    chk("sat_word_cnt", word_cnt, 5);
    chk("sat_corr_cnt", corr_cnt, 5);
    to_drive();

    // clear coincident with an output handshake
    send(7'h45);
    in_valid = 1'b0;
    to_drive();
    clr_cnt = 1'b1;
    to_drive();
    clr_cnt = 1'b0;
    @(negedge clk);
    chk("clr_hs_word_cnt", word_cnt, 0);
    chk("clr_hs_corr_cnt", corr_cnt, 0);
    chk("clr_hs_n_word", n_word_cnt, 0);
    chk("clr_hs_q_empty", q.size(), 0);
    to_drive();

    // reset with two words in flight
    send(enc(4'hA));
    send(enc(4'h5) ^ 7'h01);
    in_valid = 1'b0;
    rst = 1'b1;
    to_drive();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    repeat (5) @(negedge clk);
    chk("mid_rst_word_cnt", word_cnt, 0);
    chk("mid_rst_corr_cnt", corr_cnt, 0);
    to_drive();

    // recovery after reset
    send(enc(4'hC) ^ 7'h08);
    drain();
    chk("recover_word_cnt", word_cnt, 1);
    chk("recover_corr_cnt", corr_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hamming74_decoder.md
Name: hamming74_decoder

Overview:
- Streaming Hamming(7,4) single-error-correcting decoder.
- The receive-side counterpart of the codes_ex_top encoder. It accepts 7-bit codewords on a valid/ready interface and recomputes the syndrome.
- It corrects any single-bit error and returns the 4-bit data word through a 2-stage registered pipeline with backpressure.
- Saturating statistics counters for link-quality monitoring.

Parameters:
- CNT_W, 16, width of the word and correction counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  code_in is valid this cycle.
- in_ready  output  1  decoder accepts code_in this cycle.
- code_in  input  7  received codeword.
- out_valid  output  1  data_out, syndrome_out and err_corr are valid.
- out_ready  input  1  downstream accepts the output.
- data_out  output  4  corrected data word.
- syndrome_out  output  3  {s4,s2,s1} of the received word.
- err_corr  output  1  syndrome was non-zero and one bit was flipped.
- clr_cnt  input  1  synchronous clear of both counters.
- word_cnt  output  CNT_W  count of output handshakes, saturating.
- corr_cnt  output  CNT_W  count of output handshakes with err_corr=1, saturating.

Behaviour:
- Codeword layout (Hamming position p maps to code[p-1]):
  - code[0]=p1, code[1]=p2, code[2]=d0, code[3]=p4, code[4]=d1, code[5]=d2, code[6]=d3.
  - data[0]=d0 … data[3]=d3.
- Syndrome:
  - s1 = c0^c2^c4^c6
  - s2 = c1^c2^c5^c6
  - s4 = c3^c4^c5^c6
- Correction: a non-zero syndrome S means bit code[S-1] is inverted before data extraction. A zero syndrome passes the word unchanged.
- Double errors are not detected. They mis-correct exactly as the Hamming rule dictates, with no special handling.
- Pipeline:
  - Stage 1 registers code_in and the computed syndrome.
  - Stage 2 registers the corrected data, syndrome_out and err_corr.
  - Latency is 2 cycles from input handshake to out_valid when unstalled.
- Stage enables:
  - s2_en = !s2_valid | out_ready
  - s1_en = !s1_valid | s2_en
  - in_ready = s1_en (combinational from out_ready, allowed)
- Throughput and stalls:
  - Full throughput is 1 word/cycle.
  - Under stall, both stages hold their contents and valid bits. No word is dropped or duplicated.
  - Outputs stay stable while out_valid=1 and out_ready=0.
  - in_valid may drop without handshake; code_in is ignored when in_valid=0 or in_ready=0.
- Reset (rst=1 at a clock edge):
  - s1_valid, s2_valid and out_valid go to 0; data_out=0, syndrome_out=0, err_corr=0, word_cnt=0, corr_cnt=0.
  - in_ready is 1 from the first cycle after reset.
  - Reset mid-stream discards in-flight words and does not count them.
- Counters:
  - word_cnt increments on each out_valid&out_ready.
  - corr_cnt increments on each out_valid&out_ready&err_corr.
  - Both stick at 2^CNT_W-1 and do not wrap.
  - clr_cnt has priority over a same-cycle increment: the result is 0.
  - rst has priority over everything.

Test Plan:
- Reset, then clean code_in=7'h55 with out_ready=1 -> two cycles later data_out=4'hB, syndrome_out=3'b000, err_corr=0, word_cnt=1.
- Error in the data bit: code_in=7'h45 (code[4] flipped) -> data_out=4'hB, syndrome_out=3'b101, err_corr=1, corr_cnt=1.
- Error in the parity bit: code_in=7'h7E -> data_out=4'hF, syndrome_out=3'b001, err_corr=1. Then code_in=7'h00 -> data_out=0, err_corr=0.
- Exhaustive sweep at full rate:
  - For each of the 16 data values, encode it and send clean plus all 7 single-bit-flip variants back-to-back (128 words).
  - Required: every output data_out equals the source data, and syndrome_out equals the flipped position.
  - Required: word_cnt=128, corr_cnt=112.
- Backpressure:
  - Stream 5 words while out_ready is held low for 4 cycles.
  - Required: in_ready falls after 2 words are accepted.
  - Required: outputs are held stable, and all 5 words emerge in order once released.
- Counter edges:
  - With CNT_W=2, send 5 corrupted words -> both counters stick at 3.
  - clr_cnt asserted coincident with a handshake -> both counters read 0.
  - Asserting rst with 2 words in flight -> out_valid=0 next cycle and those words never appear.
